// File: rtl/pll_lock_supervisor.sv
// rtl/pll_lock_supervisor.sv - multi-channel PLL start-up and lock supervisor
//
// Purpose:
//   Sequences reset and static loop-filter settings for NUM_PLL PLLs, filters
//   each asynchronous lock output, retries on lock timeout and reports
//   per-channel and aggregate lock status.
//
// Ports:
//   init_clk    free-running supervisor clock
//   resetn      synchronous active-low reset
//   i_rst       per-channel restart request (active high, level or pulse)
//   pll_lock    raw asynchronous PLL lock outputs
//   pll_rst     per-channel PLL reset (active high)
//   icpsel      6-bit charge-pump select per channel
//   lpfres      3-bit loop-filter resistor per channel
//   o_lock      filtered lock per channel
//   all_locked  registered AND of o_lock
//   fail        per-channel failure flag (held until i_rst or resetn)
//
// Build option:
//   PLL_AUTO_RELOCK_EN  when defined, a lock loss restarts the channel with a
//                       fresh retry budget instead of parking it in FAIL.

module pll_lock_supervisor #(
  parameter int                   NUM_PLL         = 2,
  parameter int                   CLK_PERIOD      = 20,
  parameter logic [8*NUM_PLL-1:0] MULTI_FAC       = {NUM_PLL{8'd27}},
  parameter int                   RST_US          = 1,
  parameter int                   LOCK_TIMEOUT_US = 100,
  parameter int                   LOCK_FILTER     = 16,
  parameter int                   GLITCH_FILTER   = 4,
  parameter int                   MAX_RETRY       = 3
) (
  input  logic                 init_clk,
  input  logic                 resetn,
  input  logic [NUM_PLL-1:0]   i_rst,
  input  logic [NUM_PLL-1:0]   pll_lock,
  output logic [NUM_PLL-1:0]   pll_rst,
  output logic [6*NUM_PLL-1:0] icpsel,
  output logic [3*NUM_PLL-1:0] lpfres,
  output logic [NUM_PLL-1:0]   o_lock,
  output logic                 all_locked,
  output logic [NUM_PLL-1:0]   fail
);

  localparam int RST_CYC = (RST_US * 1000 + CLK_PERIOD - 1) / CLK_PERIOD;
  localparam int TO_CYC  = (LOCK_TIMEOUT_US * 1000 + CLK_PERIOD - 1) / CLK_PERIOD;
  localparam int CNT_MAX = (TO_CYC > RST_CYC) ? TO_CYC : RST_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int FLT_MAX = (LOCK_FILTER > GLITCH_FILTER) ? LOCK_FILTER : GLITCH_FILTER;
  localparam int FLT_W   = $clog2(FLT_MAX + 1);
  localparam int RTY_W   = ($clog2(MAX_RETRY + 1) < 1) ? 1 : $clog2(MAX_RETRY + 1);

  // Terminal values: a counter sitting at *_LAST completes its interval this cycle.
  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYC - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TO_CYC - 1);
  localparam logic [FLT_W-1:0] LF_LAST  = FLT_W'(LOCK_FILTER - 1);
  localparam logic [FLT_W-1:0] GF_LAST  = FLT_W'(GLITCH_FILTER - 1);
  localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);

  typedef enum logic [1:0] {
    ST_RESET  = 2'd0,
    ST_WAIT   = 2'd1,
    ST_LOCKED = 2'd2,
    ST_FAIL   = 2'd3
  } state_e;

  function automatic logic [5:0] icp_of(input logic [7:0] mf);
    if (mf <= 8'd16)      return 6'd8;
    else if (mf <= 8'd32) return 6'd16;
    else if (mf <= 8'd64) return 6'd24;
    else                  return 6'd32;
  endfunction

  function automatic logic [2:0] lpf_of(input logic [7:0] mf);
    if (mf <= 8'd16)      return 3'd2;
    else if (mf <= 8'd32) return 3'd3;
    else if (mf <= 8'd64) return 3'd4;
    else                  return 3'd5;
  endfunction

  // Two-flop synchroniser for the asynchronous lock inputs.
  logic [NUM_PLL-1:0] sync1_q;
  logic [NUM_PLL-1:0] sync2_q;

  always_ff @(posedge init_clk) begin
    if (!resetn) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= pll_lock;
      sync2_q <= sync1_q;
    end
  end

  logic [NUM_PLL-1:0] lock_vec;

  for (genvar g = 0; g < NUM_PLL; g++) begin : g_ch
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;   // reset pulse length / lock timeout
    logic [FLT_W-1:0] flt_q, flt_d;   // lock-high run in WAIT, lock-low run in LOCKED
    logic [RTY_W-1:0] rty_q, rty_d;
    logic             lock_q;
    logic             pll_rst_c;
    logic             fail_c;

    // State register
    always_ff @(posedge init_clk) begin
      if (!resetn) begin
        state_q <= ST_RESET;
        cnt_q   <= '0;
        flt_q   <= '0;
        rty_q   <= '0;
        lock_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        flt_q   <= flt_d;
        rty_q   <= rty_d;
        lock_q  <= (state_q == ST_LOCKED);
      end
    end

    // Next-state logic; a restart request overrides every other event.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      flt_d   = flt_q;
      rty_d   = rty_q;
      if (i_rst[g]) begin
        state_d = ST_RESET;
        cnt_d   = '0;
        flt_d   = '0;
        rty_d   = '0;
      end else begin
        case (state_q)
          ST_RESET: begin
            flt_d = '0;
            if (cnt_q == RST_LAST) begin
              state_d = ST_WAIT;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
          ST_WAIT: begin
            if (sync2_q[g] && (flt_q == LF_LAST)) begin
              state_d = ST_LOCKED;
              cnt_d   = '0;
              flt_d   = '0;
            end else if (cnt_q == TO_LAST) begin
              cnt_d = '0;
              flt_d = '0;
              if (rty_q == RTY_MAX) begin
                state_d = ST_FAIL;
              end else begin
                rty_d   = rty_q + 1'b1;
                state_d = ST_RESET;
              end
            end else begin
              cnt_d = cnt_q + 1'b1;
              flt_d = sync2_q[g] ? flt_q + 1'b1 : '0;
            end
          end
          ST_LOCKED: begin
            if (sync2_q[g]) begin
              flt_d = '0;
            end else if (flt_q == GF_LAST) begin
              flt_d = '0;
`ifdef PLL_AUTO_RELOCK_EN
              state_d = ST_RESET;
              rty_d   = '0;
`else
              state_d = ST_FAIL;
`endif
            end else begin
              flt_d = flt_q + 1'b1;
            end
          end
          ST_FAIL: begin
            state_d = ST_FAIL;
          end
          default: begin
            state_d = ST_RESET;
          end
        endcase
      end
    end

    // Output logic
    always_comb begin
      pll_rst_c = (state_q == ST_RESET) || (state_q == ST_FAIL);
      fail_c    = (state_q == ST_FAIL);
    end

    assign pll_rst[g]        = pll_rst_c;
    assign fail[g]           = fail_c;
    assign lock_vec[g]       = lock_q;
    assign icpsel[6*g +: 6]  = icp_of(MULTI_FAC[8*g +: 8]);
    assign lpfres[3*g +: 3]  = lpf_of(MULTI_FAC[8*g +: 8]);
  end

  assign o_lock = lock_vec;

  logic all_locked_q;

  always_ff @(posedge init_clk) begin
    if (!resetn) begin
      all_locked_q <= 1'b0;
    end else begin
      all_locked_q <= &lock_vec;
    end
  end

  assign all_locked = all_locked_q;

endmodule
